rtc_bus_sequencer: RTL and testbench



---
 rtl/rtc_bus_pkg.sv | 28 ++
 rtl/rtc_bus_sequencer_rr_arbiter_2.sv | 24 ++
 rtl/rtc_bus_sequencer.sv | 154 +++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus sequencer:
// state encoding, default phase timing and RTC register map.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_TURN   = 3'd3,
    ST_STROBE = 3'd4,
    ST_RECOV  = 3'd5
  } state_t;

  localparam int PHASE_CYC_DEF = 5;
  localparam int RECOV_CYC_DEF = 4;

  localparam logic [7:0] RTC_SECONDS = 8'h00;
  localparam logic [7:0] RTC_MINUTES = 8'h02;
  localparam logic [7:0] RTC_HOURS   = 8'h04;
  localparam logic [7:0] RTC_DAY     = 8'h07;
  localparam logic [7:0] RTC_MONTH   = 8'h08;
  localparam logic [7:0] RTC_YEAR    = 8'h09;
  localparam logic [7:0] RTC_REG_A   = 8'h0A;
  localparam logic [7:0] RTC_REG_B   = 8'h0B;
  localparam logic [7:0] RTC_REG_C   = 8'h0C;
  localparam logic [7:0] RTC_REG_D   = 8'h0D;

endpackage

// File: rtl/rtc_bus_sequencer_rr_arbiter_2.sv
// Two-input round-robin arbiter. The pointer holds the last winner and only
// moves when the sequencer accepts a grant, so idle cycles never rotate it.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       win,
  output logic       any
);

  logic last;

  assign any = |req;

  // On contention the requester that did not win last time goes first.
  always_comb win = (req == 2'b11) ? ~last : req[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last <= 1'b1;
    else if (accept) last <= win;
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the RTC multiplexed AD bus: arbitrates two requesters and runs
// each read/write through ADDR, HOLD, TURN, STROBE and RECOV with registered strobes.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  parameter int RECOV_CYC = RECOV_CYC_DEF,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOV_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;

  logic arb_win;
  logic arb_any;
  logic accept;

  assign accept = (state == ST_IDLE) && arb_any;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .win    (arb_win),
    .any    (arb_any)
  );

  // Every bus output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      gnt     <= 2'b00;
      done    <= 2'b00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      a_d     <= 1'b0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      cnt  <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (arb_any) begin
            owner   <= arb_win;
            we_q    <= we[arb_win];
            addr_q  <= arb_win ? addr1 : addr0;
            wdata_q <= arb_win ? wdata1 : wdata0;
            gnt     <= arb_win ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            a_d     <= 1'b1;
            ad_oe   <= 1'b1;
            ad_out  <= arb_win ? addr1 : addr0;
            cs_n    <= 1'b1;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cnt == PH_LAST) begin
            cnt   <= '0;
            a_d   <= 1'b0;
            cs_n  <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == PH_LAST) begin
            cnt   <= '0;
            ad_oe <= we_q;
            if (we_q) ad_out <= wdata_q;
            state <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (cnt == PH_LAST) begin
            cnt   <= '0;
            rd_n  <= we_q;
            wr_n  <= ~we_q;
            state <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (cnt == PH_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            done  <= owner ? 2'b10 : 2'b01;
            if (!we_q) rdata <= ad_in;
            state <= ST_RECOV;
          end
        end
        ST_RECOV: begin
          // Write data is held for the first recovery cycle only.
          ad_oe <= 1'b0;
          if (cnt == RC_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          a_d   <= 1'b0;
          ad_oe <= 1'b0;
          cs_n  <= 1'b1;
          rd_n  <= 1'b1;
          wr_n  <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: per-cycle expected bus waveform is
// derived from the phase index of each transaction and a round-robin model.
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  localparam int P = 2;
  localparam int R = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, we;
  logic [7:0] addr0, addr1, wdata0, wdata1, ad_in;
  logic [1:0] gnt, done;
  logic [7:0] rdata, ad_out;
  logic       busy, ad_oe, a_d, cs_n, rd_n, wr_n;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  int         m_last;
  logic [7:0] m_rdata;
  int         last_gnt_cyc;
  logic       s_we;
  logic [7:0] s_addr, s_wdata;

  rtc_bus_sequencer #(.PHASE_CYC(P), .RECOV_CYC(R), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waits for a grant and checks it against the round-robin model.
  task automatic wait_gnt(output int owner, output int gap);
    int exp_o;
    int n;
    n = 0;
    exp_o = (req == 2'b11) ? ((m_last == 0) ? 1 : 0) : (req[1] ? 1 : 0);
    while (gnt == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (gnt !== 2'(1 << exp_o))
      $display("FAIL grant: got %b exp %b after %0d cycles", gnt, 2'(1 << exp_o), n);
    else n_pass++;
    owner = exp_o;
    m_last = exp_o;
    gap = cyc - last_gnt_cyc;
    last_gnt_cyc = cyc;
    s_we    = we[exp_o];
    s_addr  = exp_o ? addr1 : addr0;
    s_wdata = exp_o ? wdata1 : wdata0;
  endtask

  // Called on the negedge where gnt is visible; checks every cycle to the next IDLE.
  task automatic run_txn(input int owner, input logic [1:0] drop_mask,
                         input bit raise1, input bit mutate);
    logic [7:0] cap;
    logic [9:0] e_vec, o_vec;
    logic [7:0] e_out;
    logic       e_oe;
    int ph, j;
    cap = 8'h00;
    for (int k = 0; k < 4*P + R; k++) begin
      ph = (k < 4*P) ? k / P : 4;
      j  = k - 4*P;
      e_oe  = (ph <= 1) || (ph >= 2 && ph <= 3 && s_we) || (ph == 4 && j == 0 && s_we);
      e_out = (ph <= 1) ? s_addr : s_wdata;
      e_vec = {ph == 0, !(ph >= 1 && ph <= 3), !(ph == 3 && !s_we), !(ph == 3 && s_we),
               e_oe, 1'b1, (k == 0) ? 2'(1 << owner) : 2'b00,
               (k == 4*P) ? 2'(1 << owner) : 2'b00};
      o_vec = {a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done};
      n_chk++;
      if (o_vec !== e_vec)
        $display("FAIL bus_ctl k=%0d {a_d,cs,rd,wr,oe,busy,gnt,done}: got %b exp %b", k, o_vec, e_vec);
      else n_pass++;
      if (e_oe) begin
        n_chk++;
        if (ad_out !== e_out) $display("FAIL ad_out k=%0d: got %h exp %h", k, ad_out, e_out);
        else n_pass++;
      end
      if (k == 4*P) begin
        if (!s_we) m_rdata = cap;
        n_chk++;
        if (rdata !== m_rdata) $display("FAIL rdata: got %h exp %h", rdata, m_rdata);
        else n_pass++;
      end
      ad_in = 8'($urandom);
      if (k == 4*P - 1) cap = ad_in;
      if (raise1 && k == P) req[1] = 1'b1;
      if (mutate && k == 2*P) begin
        addr0 = 8'($urandom); addr1 = 8'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        we = 2'($urandom);
      end
      if (k == 4*P) req = req & ~drop_mask;
      @(negedge clk);
    end
    o_vec = {a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done};
    n_chk++;
    if (o_vec !== 10'b0111000000) $display("FAIL idle_after: got %b exp 0111000000", o_vec);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last  = 1;
    m_rdata = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b00; we = 2'b00; addr0 = 8'h00; addr1 = 8'h00;
    wdata0 = 8'h00; wdata1 = 8'h00; ad_in = 8'h00;
    #1;
    n_chk++;
    if ({a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done} !== 10'b0111000000)
      $display("FAIL reset_ctl: got %b exp 0111000000", {a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done});
    else n_pass++;
    n_chk++;
    if ({rdata, ad_out} !== 16'h0000) $display("FAIL reset_data: got %h exp 0000", {rdata, ad_out});
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_last = 1;
    m_rdata = 8'h00;
    last_gnt_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int o, g;
    we = 2'b00; addr0 = RTC_HOURS; req = 2'b01;
    wait_gnt(o, g);
    run_txn(o, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_single_write();
    int o, g;
    we = 2'b10; addr1 = RTC_REG_B; wdata1 = 8'h86; req = 2'b10;
    wait_gnt(o, g);
    run_txn(o, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int o, g;
    do_reset();
    we = 2'($urandom); addr0 = 8'($urandom); addr1 = 8'($urandom);
    wdata0 = 8'($urandom); wdata1 = 8'($urandom);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(o, g);
      if (i > 0) begin
        n_chk++;
        if (g !== 4*P + R + 1) $display("FAIL b2b_period: got %0d exp %0d", g, 4*P + R + 1);
        else n_pass++;
      end
      run_txn(o, (i == 3) ? 2'b11 : 2'b00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_busy_request();
    int o, g;
    we = 2'($urandom); addr0 = 8'($urandom); addr1 = 8'($urandom);
    req = 2'b01;
    wait_gnt(o, g);
    run_txn(o, 2'b01, 1'b1, 1'b0);
    wait_gnt(o, g);
    n_chk++;
    if (g !== 4*P + R + 1) $display("FAIL busy_req_latency: got %0d exp %0d", g, 4*P + R + 1);
    else n_pass++;
    run_txn(o, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic test_random_mutate();
    int o, g;
    for (int i = 0; i < 12; i++) begin
      we = 2'($urandom); addr0 = 8'($urandom); addr1 = 8'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      req = 2'($urandom_range(1, 3));
      wait_gnt(o, g);
      run_txn(o, 2'b11, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_strobe();
    int o, g;
    we = 2'b01; addr0 = RTC_MINUTES; wdata0 = 8'($urandom); req = 2'b01;
    wait_gnt(o, g);
    repeat (3*P) @(negedge clk);
    n_chk++;
    if (wr_n !== 1'b0) $display("FAIL pre_abort_wr_n: got %b exp 0", wr_n);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done} !== 10'b0111000000)
      $display("FAIL abort_ctl: got %b exp 0111000000", {a_d, cs_n, rd_n, wr_n, ad_oe, busy, gnt, done});
    else n_pass++;
    n_chk++;
    if (rdata !== 8'h00) $display("FAIL abort_rdata: got %h exp 00", rdata);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 2'b00) $display("FAIL abort_done: got %b exp 00", done);
      else n_pass++;
    end
    reset = 1'b0;
    m_last = 1;
    m_rdata = 8'h00;
    we = 2'($urandom); req = 2'b11;
    wait_gnt(o, g);
    run_txn(o, 2'b11, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_busy_request();
    test_random_mutate();
    test_reset_mid_strobe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
